rr_arb4_ctrl: RTL
=================

Name: rr_arb4_ctrl

Overview:
- Four-requester round-robin arbiter with grant locking and bounded hold time.
- Shares a single resource (e.g. the AES-128 round datapath or a shared key/state bus) among four clients.
- Registered one-hot grant, grant index, and a registered OR-reduction of requests (any_req) for downstream enable logic.
- Sits between the client request lines and the shared resource's select/enable mux.

Parameters:
- MAX_HOLD, 16, max consecutive cycles one owner keeps the grant while another requester waits; 0 = unlimited (no preemption).
- CNT_W, 5, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- req  input  4  level requests; req[i] high = client i wants the resource
- gnt  output 4  registered one-hot grant, all-zero when idle
- gnt_id  output 2  registered index of current owner; holds last value when idle
- busy  output 1  registered; high whenever gnt != 0
- any_req  output 1  registered OR of req[3:0] (one-cycle delayed)
- preempt  output 1  one-cycle pulse on the cycle gnt changes because of a MAX_HOLD timeout

Behaviour:
- Reset (rst=1 at an edge): gnt=0, gnt_id=0, busy=0, any_req=0, preempt=0, hold_cnt=0, priority pointer ptr=0 (client 0 highest). Reset mid-grant drops gnt the next edge; no partial state survives.
- Priority search: starting at index ptr, scan ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first asserted req in that order wins.
- States: IDLE (gnt=0), OWNED (gnt one-hot).
- IDLE:
  - If any req is high at edge t, gnt/gnt_id/busy update at that edge, so gnt is visible in the cycle after req is sampled (1-cycle latency).
  - hold_cnt := 1 on the new grant.
  - If no req, stay IDLE.
- OWNED, owner g = gnt_id. Conditions below are evaluated at each edge in the order listed.
  - Release: req[g]=0.
    - ptr := g+1 (mod 4).
    - If other reqs are high, grant passes directly to the winner of the search from g+1. There is no idle cycle, hold_cnt := 1, and preempt stays 0.
    - Otherwise go to IDLE with gnt=0.
  - Preempt: req[g]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD, and any other req high.
    - Grant moves to the winner of the search from g+1, with ptr := g+1, hold_cnt := 1, and preempt=1 for exactly that cycle.
    - Result: the owner holds at most MAX_HOLD cycles.
  - Hold: otherwise keep gnt. hold_cnt increments, saturating at MAX_HOLD (or at 2^CNT_W-1 when MAX_HOLD=0).
  - A sole requester is never preempted, regardless of hold_cnt.
- Invariants:
  - gnt is always zero or one-hot.
  - busy == |gnt.
  - A request that stays asserted is granted within 3*MAX_HOLD+3 cycles when MAX_HOLD>0.
- any_req is a plain registered OR. It is independent of grant state and also updates while owned.
- req changes in the same cycle as a release are sampled together; a newly asserted req may win the handoff.

Test Plan:
- Reset, then req=4'b1010 held → one cycle later gnt=4'b0010, gnt_id=1, busy=1, any_req=1; gnt stable while req[1]=1 and MAX_HOLD not reached.
- MAX_HOLD=4, req=4'b1111 held → gnt sequence 0001 ×4, 0010 ×4, 0100 ×4, 1000 ×4, 0001 ...; preempt=1 on each of the 4 transition cycles only.
- Owner 0 granted with req[3] high; drop req[0] → gnt goes 0001→1000 at the next edge with no zero cycle; preempt=0; hold_cnt restarts (req[3] then held 4 cycles before any preempt).
- Single requester req=4'b0100 held 40 cycles with MAX_HOLD=4 → gnt=0100 throughout, preempt never asserts; drop req → gnt=0, busy=0 next cycle.
- Grant active (gnt=0100), assert rst for 1 cycle with req=4'b1111 → gnt=0, busy=0, gnt_id=0; after rst drops, the first grant is 0001 (ptr reset to 0).
- MAX_HOLD=0, req=4'b0011 for 100 cycles → client 0 keeps grant all 100 cycles; release req[0] → gnt=0010 next edge.

Source files
------------

// File: rtl/rr_arb4_if.sv
// Request/grant bundle between four clients and the round-robin arbiter.
// master = client side, slave = arbiter side.
interface rr_arb4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       any_req;
    logic       preempt;

    modport master (output req, input gnt, gnt_id, busy, any_req, preempt);
    modport slave  (input req, output gnt, gnt_id, busy, any_req, preempt);
endinterface

// File: rtl/rr_arb4_ctrl.sv
// Four-client round-robin arbiter with grant locking and a bounded hold time.
// All outputs are registered; MAX_HOLD=0 disables timeout preemption.
module rr_arb4_ctrl #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    rr_arb4_if.slave    arb
);

    typedef enum logic [0:0] {IDLE, OWNED} state_t;

    // Saturation point of the hold counter
    localparam logic [CNT_W-1:0] HOLD_MAX =
        (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [1:0] start;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       others;

    // While owned, the search always starts just past the owner
    always_comb begin
        start = (state == OWNED) ? arb.gnt_id + 2'd1 : ptr;
        found = 1'b0;
        win   = start;
        idx   = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (arb.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        others = |(arb.req & ~(4'b0001 << arb.gnt_id));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            hold_cnt    <= '0;
            arb.gnt     <= 4'b0000;
            arb.gnt_id  <= 2'd0;
            arb.busy    <= 1'b0;
            arb.any_req <= 1'b0;
            arb.preempt <= 1'b0;
        end else begin
            arb.any_req <= |arb.req;
            arb.preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= OWNED;
                        arb.gnt    <= 4'b0001 << win;
                        arb.gnt_id <= win;
                        arb.busy   <= 1'b1;
                        hold_cnt   <= CNT_W'(1);
                    end
                end
                OWNED: begin
                    if (!arb.req[arb.gnt_id]) begin
                        ptr <= arb.gnt_id + 2'd1;
                        if (others) begin
                            arb.gnt    <= 4'b0001 << win;
                            arb.gnt_id <= win;
                            hold_cnt   <= CNT_W'(1);
                        end else begin
                            state    <= IDLE;
                            arb.gnt  <= 4'b0000;
                            arb.busy <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end else if (MAX_HOLD != 0 && hold_cnt == HOLD_MAX && others) begin
                        ptr         <= arb.gnt_id + 2'd1;
                        arb.gnt     <= 4'b0001 << win;
                        arb.gnt_id  <= win;
                        hold_cnt    <= CNT_W'(1);
                        arb.preempt <= 1'b1;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
